// File: rtl/multicycle_control.sv
// Main control FSM and ALU decoder for the 32-bit multicycle processor.
// Moore outputs decoded from State; PCEn also depends on the ALU Zero flag.
//
// state   | meaning
// FETCH   | read instruction at PC, PC <= PC + 4
// DECODE  | read registers, precompute branch target
// MEMADR  | compute load/store address
// MEMRD   | read data memory
// MEMWB   | write load data to rt
// MEMWR   | write data memory
// EXECUTE | R-type ALU operation
// ALUWB   | write ALU result to rd
// BRANCH  | compare operands, take branch on Zero
// ADDIEX  | add sign-extended immediate
// ADDIWB  | write ADDI result to rt
// JUMP    | load jump target into PC
module multicycle_control #(
  parameter logic [2:0] ALU_AND = 3'b000,
  parameter logic [2:0] ALU_OR  = 3'b001,
  parameter logic [2:0] ALU_ADD = 3'b010,
  parameter logic [2:0] ALU_SUB = 3'b110,
  parameter logic [2:0] ALU_SLT = 3'b111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic [2:0] ALUop,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       PCEn,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state, state_next;
  logic   pc_write, branch, ir_write, mem_write, reg_write;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    ALUop      = ALU_ADD;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    IorD       = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcB    = 2'b01;
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECUTE;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JUMP;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = (Op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        IorD       = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        MemtoReg  = 1'b1;
        reg_write = 1'b1;
      end
      MEMWR: begin
        IorD      = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        case (Funct)
          6'b100010: ALUop = ALU_SUB;
          6'b100100: ALUop = ALU_AND;
          6'b100101: ALUop = ALU_OR;
          6'b101010: ALUop = ALU_SLT;
          default:   ALUop = ALU_ADD;
        endcase
        state_next = ALUWB;
      end
      ALUWB: begin
        RegDst    = 1'b1;
        reg_write = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUop   = ALU_SUB;
        PCSrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = ADDIWB;
      end
      ADDIWB: reg_write = 1'b1;
      JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: state_next = FETCH;
    endcase
  end

  // Enables are gated by reset so an aborted instruction never half-commits.
  assign IRWrite  = rst_n & ir_write;
  assign MemWrite = rst_n & mem_write;
  assign RegWrite = rst_n & reg_write;
  assign PCEn     = rst_n & (pc_write | (branch & Zero));
  assign State    = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: expected output vectors per cycle are
// queued from a spec-table model and compared against the DUT each cycle.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Op, Funct;
  logic       Zero;
  logic [2:0] ALUop;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic       IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, PCEn;
  logic [3:0] State;

  int tests  = 0;
  int errors = 0;
  logic [18:0] sb [$];

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero),
    .ALUop(ALUop), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .PCEn(PCEn), .State(State)
  );

  wire [18:0] obs = {State, ALUop, ALUSrcA, ALUSrcB, PCSrc, IorD, IRWrite,
                     MemWrite, RegWrite, RegDst, MemtoReg, PCEn};

  // Output table from the state description; rb is the reset-released flag.
  function automatic logic [18:0] model(input logic [3:0] st, input logic [5:0] fn,
                                        input logic z, input logic rb);
    logic [2:0] aop;
    logic       sa, iord, irw, memw, regw, rdst, m2r, pcw, br;
    logic [1:0] sb_, pcs;
    aop = 3'b010; sa = 0; sb_ = 2'b00; pcs = 2'b00; iord = 0; irw = 0;
    memw = 0; regw = 0; rdst = 0; m2r = 0; pcw = 0; br = 0;
    case (st)
      4'd0:  begin sb_ = 2'b01; irw = 1; pcw = 1; end
      4'd1:  sb_ = 2'b11;
      4'd2:  begin sa = 1; sb_ = 2'b10; end
      4'd3:  iord = 1;
      4'd4:  begin m2r = 1; regw = 1; end
      4'd5:  begin iord = 1; memw = 1; end
      4'd6:  begin
        sa = 1;
        case (fn)
          6'b100010: aop = 3'b110;
          6'b100100: aop = 3'b000;
          6'b100101: aop = 3'b001;
          6'b101010: aop = 3'b111;
          default:   aop = 3'b010;
        endcase
      end
      4'd7:  begin rdst = 1; regw = 1; end
      4'd8:  begin sa = 1; aop = 3'b110; pcs = 2'b01; br = 1; end
      4'd9:  begin sa = 1; sb_ = 2'b10; end
      4'd10: regw = 1;
      4'd11: begin pcs = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {st, aop, sa, sb_, pcs, iord, irw & rb, memw & rb, regw & rb,
            rdst, m2r, rb & (pcw | (br & z))};
  endfunction

  task automatic check(input string tag);
    logic [18:0] e;
    tests++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  // Called at a negedge with DUT in FETCH; returns at the negedge after the
  // last listed state. seq holds up to 6 states, first in the top nibble.
  // Op switches to op_late after the comparison at index late_at.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic [23:0] seq, input int n,
                           input int late_at, input logic [5:0] op_late);
    Op = op; Funct = fn; Zero = z;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      sb.push_back(model(seq[23-4*i -: 4], fn, z, 1'b1));
      check($sformatf("%s[%0d]", tag, i));
      if (i == late_at) Op = op_late;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; Op = 6'b101011; Funct = 6'b0; Zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    sb.push_back(model(4'd0, Funct, Zero, 1'b0));
    check("por");
    rst_n = 1'b1;

    // Store aborted in MEMWR by a two-cycle reset
    run_instr("sw_abort", 6'b101011, 6'h00, 1'b1, {4'd0, 4'd1, 4'd2, 12'h0}, 3, -1, 6'd0);
    rst_n = 1'b0; #1;
    sb.push_back(model(4'd5, Funct, Zero, 1'b0));
    check("rst_in_memwr");
    @(negedge clk); #1;
    sb.push_back(model(4'd0, Funct, Zero, 1'b0));
    check("rst_cycle1");
    @(negedge clk); #1;
    sb.push_back(model(4'd0, Funct, Zero, 1'b0));
    check("rst_cycle2");
    rst_n = 1'b1; #1;
    sb.push_back(model(4'd0, Funct, Zero, 1'b1));
    check("rst_release");

    // R-type SUB with Zero held high: no branch PCEn outside BRANCH
    run_instr("sub", 6'b000000, 6'b100010, 1'b1, {4'd0, 4'd1, 4'd6, 4'd7, 8'h0}, 4, -1, 6'd0);
    // LW; Op changes during MEMRD must not redirect it
    run_instr("lw", 6'b100011, 6'h3f, 1'b0, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0}, 5, 3, 6'b101011);
    run_instr("sw", 6'b101011, 6'h00, 1'b0, {4'd0, 4'd1, 4'd2, 4'd5, 8'h0}, 4, -1, 6'd0);
    run_instr("beq_t", 6'b000100, 6'h00, 1'b1, {4'd0, 4'd1, 4'd8, 12'h0}, 3, -1, 6'd0);
    run_instr("beq_nt", 6'b000100, 6'h00, 1'b0, {4'd0, 4'd1, 4'd8, 12'h0}, 3, -1, 6'd0);
    run_instr("and", 6'b000000, 6'b100100, 1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 8'h0}, 4, -1, 6'd0);
    run_instr("or", 6'b000000, 6'b100101, 1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 8'h0}, 4, -1, 6'd0);
    run_instr("slt", 6'b000000, 6'b101010, 1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 8'h0}, 4, -1, 6'd0);
    run_instr("fdef", 6'b000000, 6'b111111, 1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 8'h0}, 4, -1, 6'd0);
    run_instr("addi", 6'b001000, 6'h00, 1'b0, {4'd0, 4'd1, 4'd9, 4'd10, 8'h0}, 4, -1, 6'd0);
    run_instr("j", 6'b000010, 6'h00, 1'b1, {4'd0, 4'd1, 4'd11, 12'h0}, 3, -1, 6'd0);
    run_instr("illegal", 6'b111111, 6'h00, 1'b0, {4'd0, 4'd1, 16'h0}, 2, -1, 6'd0);
    run_instr("tail", 6'b000000, 6'h00, 1'b0, {4'd0, 20'h0}, 1, -1, 6'd0);

    tests++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain: observed %0d left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
